// File: rtl/mem_pkg.sv
// Shared memory-operation definitions: 68-bit op packing, its field slices and
// the client identifiers used by the arbiter and its tag FIFO.
package mem_pkg;

    localparam int MEM_OP_SIZE    = 68;
    localparam int REQ_ADDR_WIDTH = 32;
    localparam int REQ_DATA_WIDTH = 32;
    localparam int BYTE_EN_WIDTH  = 4;

    localparam int DATA_LSB    = 0;
    localparam int DATA_MSB    = DATA_LSB + REQ_DATA_WIDTH - 1;
    localparam int ADDR_LSB    = DATA_MSB + 1;
    localparam int ADDR_MSB    = ADDR_LSB + REQ_ADDR_WIDTH - 1;
    localparam int BYTE_EN_LSB = ADDR_MSB + 1;
    localparam int BYTE_EN_MSB = BYTE_EN_LSB + BYTE_EN_WIDTH - 1;

    // Field order matches {byte_en, addr, data}, so a packed op is the raw 68-bit word.
    typedef struct packed {
        logic [BYTE_EN_WIDTH-1:0]  byte_en;
        logic [REQ_ADDR_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0] data;
    } mem_op_t;

    typedef enum logic {
        CLIENT_FETCH = 1'b0,
        CLIENT_LSU   = 1'b1
    } client_id_t;

    function automatic client_id_t other_client(input client_id_t id);
        return (id == CLIENT_FETCH) ? CLIENT_LSU : CLIENT_FETCH;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bus between the two clients, the arbiter and the memory put/get ports.
interface mem_arbiter_if;
    import mem_pkg::*;

    logic    c0_req_valid;
    logic    c0_req_ready;
    mem_op_t c0_req;
    logic    c0_rsp_valid;
    logic    c0_rsp_ready;
    mem_op_t c0_rsp;

    logic    c1_req_valid;
    logic    c1_req_ready;
    mem_op_t c1_req;
    logic    c1_rsp_valid;
    logic    c1_rsp_ready;
    mem_op_t c1_rsp;

    logic    mem_put_valid;
    logic    mem_put_ready;
    mem_op_t mem_put_request;
    logic    mem_get_valid;
    logic    mem_get_ready;
    mem_op_t mem_get_response;

    // Arbiter side: drives the memory put/get and the per-client handshakes.
    modport master (
        input  c0_req_valid, c0_req, c0_rsp_ready,
        input  c1_req_valid, c1_req, c1_rsp_ready,
        input  mem_put_ready, mem_get_ready, mem_get_response,
        output c0_req_ready, c0_rsp_valid, c0_rsp,
        output c1_req_ready, c1_rsp_valid, c1_rsp,
        output mem_put_valid, mem_put_request, mem_get_valid
    );

    // Environment side: clients plus the memory model.
    modport slave (
        output c0_req_valid, c0_req, c0_rsp_ready,
        output c1_req_valid, c1_req, c1_rsp_ready,
        output mem_put_ready, mem_get_ready, mem_get_response,
        input  c0_req_ready, c0_rsp_valid, c0_rsp,
        input  c1_req_ready, c1_rsp_valid, c1_rsp,
        input  mem_put_valid, mem_put_request, mem_get_valid
    );

endinterface

// File: rtl/mem_arbiter_tag_fifo.sv
// Synchronous FIFO with occupancy count; holds the issuing-client tag of every
// memory request that has been accepted but whose response has not returned.
module tag_fifo #(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;

    // NOTE: storage has no reset; r_count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory put/get port between fetch (c0) and
// load/store (c1); responses are routed back in order using a tag FIFO.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input logic           CLK,
    input logic           RST_N,
    mem_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    client_id_t       r_prio;
    logic             r_lock_valid;
    client_id_t       r_lock_id;

    logic             w_grant_valid;
    client_id_t       w_grant_id;
    logic             w_put_valid;
    logic             w_xfer;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CNT_W-1:0] w_fifo_count;
    logic [0:0]       w_head_bits;
    client_id_t       w_head;
    logic             w_rsp_active;
    logic             w_get_valid;
    logic             w_pop;

    // A stalled offer keeps the bus until memory takes it; otherwise round-robin.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        w_grant_valid = 1'b0;
        w_grant_id    = CLIENT_FETCH;
        if (r_lock_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = r_lock_id;
        end else if (bus.c0_req_valid && bus.c1_req_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = r_prio;
        end else if (bus.c0_req_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = CLIENT_FETCH;
        end else if (bus.c1_req_valid) begin
            w_grant_valid = 1'b1;
            w_grant_id    = CLIENT_LSU;
        end
    end

    // Full blocks issue even when a pop lands in the same cycle.
    assign w_put_valid         = RST_N && w_grant_valid && !w_fifo_full;
    assign w_xfer              = w_put_valid && bus.mem_put_ready;

    assign bus.mem_put_valid   = w_put_valid;
    assign bus.mem_put_request = (w_grant_id == CLIENT_LSU) ? bus.c1_req : bus.c0_req;
    assign bus.c0_req_ready    = w_xfer && (w_grant_id == CLIENT_FETCH);
    assign bus.c1_req_ready    = w_xfer && (w_grant_id == CLIENT_LSU);

    assign w_head              = client_id_t'(w_head_bits);
    assign w_rsp_active        = RST_N && !w_fifo_empty;

    assign bus.c0_rsp_valid    = w_rsp_active && (w_head == CLIENT_FETCH) && bus.mem_get_ready;
    assign bus.c1_rsp_valid    = w_rsp_active && (w_head == CLIENT_LSU) && bus.mem_get_ready;
    assign bus.c0_rsp          = bus.mem_get_response;
    assign bus.c1_rsp          = bus.mem_get_response;

    assign w_get_valid         = w_rsp_active &&
                                 ((w_head == CLIENT_FETCH) ? bus.c0_rsp_ready : bus.c1_rsp_ready);
    assign bus.mem_get_valid   = w_get_valid;
    assign w_pop               = w_get_valid && bus.mem_get_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_prio       <= CLIENT_FETCH;
            r_lock_valid <= 1'b0;
            r_lock_id    <= CLIENT_FETCH;
        end else if (w_xfer) begin
            r_prio       <= other_client(w_grant_id);
            r_lock_valid <= 1'b0;
        end else if (w_put_valid) begin
            r_lock_valid <= 1'b1;
            r_lock_id    <= w_grant_id;
        end
    end

    tag_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk         (CLK),
        .rst_n       (RST_N),
        .i_push      (w_xfer),
        .i_push_data (w_grant_id),
        .i_pop       (w_pop),
        .o_pop_data  (w_head_bits),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    a_count_bounded: assert property (@(posedge CLK) disable iff (!RST_N)
        w_fifo_count <= CNT_W'(MAX_OUTSTANDING));

    a_grant_held: assert property (@(posedge CLK) disable iff (!RST_N)
        (w_put_valid && !bus.mem_put_ready) |=> (w_grant_valid && w_grant_id == $past(w_grant_id)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: TB-side memory and clients, checked against a
// transaction-level reference of round-robin issue and in-order response return.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int MAX_OUT   = 2;
    localparam int MEM_WORDS = 128;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Environment: client stimulus and memory model.
    logic [1:0]  cv;
    mem_op_t     creq [2];
    logic [1:0]  crr;
    logic        put_rdy;
    logic        env_get_ready;
    mem_op_t     env_q [$];
    logic [31:0] env_mem [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    // Reference: who may issue next, outstanding issuers in order, expected replies.
    logic        m_prio;
    logic        m_lock_v;
    logic        m_lock_id;
    bit          m_tags [$];
    mem_op_t     exp_q0 [$];
    mem_op_t     exp_q1 [$];

    // DUT outputs seen in the last step.
    logic        cap_put_valid;
    mem_op_t     cap_put_req;
    logic [1:0]  cap_req_ready;
    logic [1:0]  cap_rsp_valid;
    logic        cap_get_valid;
    mem_op_t     cap_c0_rsp;
    mem_op_t     cap_c1_rsp;

    task automatic drive_bus();
        bus.c0_req_valid     = cv[0];
        bus.c0_req           = creq[0];
        bus.c0_rsp_ready     = crr[0];
        bus.c1_req_valid     = cv[1];
        bus.c1_req           = creq[1];
        bus.c1_rsp_ready     = crr[1];
        bus.mem_put_ready    = put_rdy;
        bus.mem_get_ready    = env_get_ready;
        bus.mem_get_response = (env_q.size() > 0) ? env_q[0] : '0;
    endtask

    task automatic apply_op(input bit use_ref, input mem_op_t op, output mem_op_t rsp);
        int          w;
        logic [31:0] word;
        w    = int'(op.addr[8:2]);
        word = use_ref ? ref_mem[w] : env_mem[w];
        rsp  = op;
        if (op.byte_en == 4'h0) begin
            rsp.data = word;
        end else begin
            rsp.data = '0;
            for (int b = 0; b < 4; b++) begin
                if (op.byte_en[b]) word[8*b +: 8] = op.data[8*b +: 8];
            end
            if (use_ref) ref_mem[w] = word;
            else         env_mem[w] = word;
        end
    endtask

    function automatic mem_op_t rand_op();
        mem_op_t op;
        op.byte_en = ($urandom_range(0, 99) < 60) ? 4'h0 : 4'($urandom_range(1, 15));
        op.addr    = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
        op.data    = $urandom;
        return op;
    endfunction

    task automatic refill();
        for (int i = 0; i < 2; i++) begin
            if (!cv[i]) begin
                cv[i]   = 1'b1;
                creq[i] = rand_op();
            end
        end
    endtask

    // One clock: called just after a rising edge, returns just after the next one.
    task automatic step();
        logic       g_has;
        logic       g_id;
        logic       e_put_valid;
        logic       e_xfer;
        logic       e_pop;
        logic [1:0] e_rsp_valid;
        logic       e_get_valid;
        bit         h;
        mem_op_t    r;

        drive_bus();
        #1;
        g_has = 1'b1;
        g_id  = 1'b0;
        if (m_lock_v)        g_id  = m_lock_id;
        else if (cv == 2'b11) g_id = m_prio;
        else if (cv[0])      g_id  = 1'b0;
        else if (cv[1])      g_id  = 1'b1;
        else                 g_has = 1'b0;
        e_put_valid = g_has && (m_tags.size() < MAX_OUT);
        e_xfer      = e_put_valid && put_rdy;

        check("put_valid", bus.mem_put_valid, e_put_valid);
        if (e_put_valid) check("put_request", bus.mem_put_request, creq[g_id]);
        check("c0_req_ready", bus.c0_req_ready, e_xfer && !g_id);
        check("c1_req_ready", bus.c1_req_ready, e_xfer && g_id);

        e_rsp_valid = 2'b00;
        e_get_valid = 1'b0;
        h           = 1'b0;
        if (m_tags.size() > 0) begin
            h              = m_tags[0];
            e_rsp_valid[h] = env_get_ready;
            e_get_valid    = crr[h];
        end
        check("c0_rsp_valid", bus.c0_rsp_valid, e_rsp_valid[0]);
        check("c1_rsp_valid", bus.c1_rsp_valid, e_rsp_valid[1]);
        check("get_valid", bus.mem_get_valid, e_get_valid);
        e_pop = e_get_valid && env_get_ready;
        if (e_pop) begin
            if (h) check("c1_rsp", bus.c1_rsp, exp_q1[0]);
            else   check("c0_rsp", bus.c0_rsp, exp_q0[0]);
        end

        cap_put_valid = bus.mem_put_valid;
        cap_put_req   = bus.mem_put_request;
        cap_req_ready = {bus.c1_req_ready, bus.c0_req_ready};
        cap_rsp_valid = {bus.c1_rsp_valid, bus.c0_rsp_valid};
        cap_get_valid = bus.mem_get_valid;
        cap_c0_rsp    = bus.c0_rsp;
        cap_c1_rsp    = bus.c1_rsp;

        @(posedge clk);
        #1;
        if (e_pop) begin
            void'(m_tags.pop_front());
            if (h) void'(exp_q1.pop_front());
            else   void'(exp_q0.pop_front());
        end
        if (e_xfer) begin
            m_tags.push_back(g_id);
            apply_op(1'b1, creq[g_id], r);
            if (g_id) exp_q1.push_back(r);
            else      exp_q0.push_back(r);
            m_prio   = !g_id;
            m_lock_v = 1'b0;
        end else if (e_put_valid) begin
            m_lock_v  = 1'b1;
            m_lock_id = g_id;
        end

        if (cap_get_valid && env_get_ready && env_q.size() > 0) void'(env_q.pop_front());
        if (cap_put_valid && put_rdy) begin
            apply_op(1'b0, cap_put_req, r);
            env_q.push_back(r);
        end
        env_get_ready = (env_q.size() > 0);
        for (int i = 0; i < 2; i++) begin
            if (cap_req_ready[i]) cv[i] = 1'b0;
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_c0_req_ready"}, bus.c0_req_ready, 1'b0);
        check({tag, "_c1_req_ready"}, bus.c1_req_ready, 1'b0);
        check({tag, "_c0_rsp_valid"}, bus.c0_rsp_valid, 1'b0);
        check({tag, "_c1_rsp_valid"}, bus.c1_rsp_valid, 1'b0);
        check({tag, "_put_valid"}, bus.mem_put_valid, 1'b0);
        check({tag, "_get_valid"}, bus.mem_get_valid, 1'b0);
    endtask

    task automatic clear_state();
        m_tags.delete();
        exp_q0.delete();
        exp_q1.delete();
        env_q.delete();
        m_prio        = 1'b0;
        m_lock_v      = 1'b0;
        m_lock_id     = 1'b0;
        env_get_ready = 1'b0;
    endtask

    task automatic run_random(input int n, input int pv, input int pr, input int prr);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (!cv[i] && $urandom_range(0, 99) < pv) begin
                    cv[i]   = 1'b1;
                    creq[i] = rand_op();
                end
                crr[i] = ($urandom_range(0, 99) < prr);
            end
            put_rdy = ($urandom_range(0, 99) < pr);
            step();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            env_mem[i] = $urandom;
            ref_mem[i] = env_mem[i];
        end
        clear_state();
        cv      = 2'b11;
        creq[0] = rand_op();
        creq[1] = rand_op();
        crr     = 2'b11;
        put_rdy = 1'b1;
        rst_n   = 1'b0;
        env_get_ready = 1'b1;
        drive_bus();
        #3;
        check_quiet_outputs("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single read; the spurious get_ready from reset must be ignored.
        env_mem[64] = 32'hDEADBEEF;
        ref_mem[64] = 32'hDEADBEEF;
        cv      = 2'b01;
        creq[0] = '{byte_en: 4'h0, addr: 32'h100, data: 32'h0};
        step();
        check("single_accept", cap_req_ready, 2'b01);
        check("single_no_rsp", cap_rsp_valid, 2'b00);
        step();
        check("single_rsp_valid", cap_rsp_valid, 2'b01);
        check("single_rd_data", cap_c0_rsp.data, 32'hDEADBEEF);

        // Store by c1, then load of the same word by c0.
        cv      = 2'b10;
        creq[1] = '{byte_en: 4'hF, addr: 32'h40, data: 32'h12345678};
        step();
        cv      = 2'b01;
        creq[0] = '{byte_en: 4'h0, addr: 32'h40, data: 32'h0};
        step();
        check("store_rsp_valid", cap_rsp_valid, 2'b10);
        check("store_rsp_data", cap_c1_rsp.data, 32'h0);
        step();
        check("load_rsp_valid", cap_rsp_valid, 2'b01);
        check("load_rsp_data", cap_c0_rsp.data, 32'h12345678);

        // Stall while c1 holds the grant.
        refill();
        put_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall_valid_%0d", k), cap_put_valid, 1'b1);
            check($sformatf("stall_req_%0d", k), cap_put_req, creq[1]);
        end
        put_rdy = 1'b1;
        step();
        check("stall_release", cap_req_ready, 2'b10);
        refill();
        step();
        check("stall_next", cap_req_ready, 2'b01);
        cv = 2'b00;
        step();
        step();

        // Full tag FIFO blocks a third offer, including in the pop cycle.
        crr = 2'b00;
        refill();
        step();
        refill();
        step();
        refill();
        step();
        check("full_block", cap_put_valid, 1'b0);
        crr = 2'b11;
        step();
        check("full_no_bypass", cap_put_valid, 1'b0);
        step();
        check("full_resume", cap_put_valid, 1'b1);

        // Reset with two requests outstanding.
        crr = 2'b00;
        for (int k = 0; k < 3; k++) begin
            refill();
            step();
        end
        rst_n = 1'b0;
        #1;
        check_quiet_outputs("midreset");
        clear_state();
        refill();
        crr     = 2'b11;
        put_rdy = 1'b1;
        drive_bus();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Continuous contention alternates starting with c0.
        for (int k = 0; k < 6; k++) begin
            refill();
            step();
            check($sformatf("contend_%0d", k), cap_req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
        end

        run_random(300, 60, 70, 70);
        run_random(300, 90, 40, 50);
        run_random(300, 100, 100, 20);
        run_random(300, 50, 90, 90);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
